glitch_sweep_ctrl: RTL and testbench

//  Sequencer for the glitch datapath: sweeps a 2-D grid of (delay, width) points, pushing one
//  32-bit setting word per shot into the glitch FIFO write side, pulsing the glitch enable and

---
 rtl/glitch_sweep_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_ctrl.sv
// Glitch parameter sweep sequencer: walks a (delay, width) grid, writes one setting word
// per shot into the glitch FIFO, arms the core and waits for its ready handshake.
module glitch_sweep_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned WW = 16,
  parameter int unsigned RW = 8,
  parameter int unsigned TW = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DW-1:0]    delay_start_i,
  input  logic [DW-1:0]    delay_end_i,
  input  logic [DW-1:0]    delay_step_i,
  input  logic [WW-1:0]    width_start_i,
  input  logic [WW-1:0]    width_end_i,
  input  logic [WW-1:0]    width_step_i,
  input  logic [RW-1:0]    repeat_i,
  input  logic [TW-1:0]    timeout_i,
  output logic [DW+WW-1:0] fifo_dat_o,
  output logic             fifo_we_o,
  input  logic             fifo_full_i,
  output logic             en_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [DW-1:0]    cur_delay_o,
  output logic [WW-1:0]    cur_width_o,
  output logic [31:0]      shot_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_ARM,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state;

  logic          rdy_meta;
  logic          rdy_s;

  logic [DW-1:0] cfg_delay_start;
  logic [DW-1:0] cfg_delay_end;
  logic [DW-1:0] cfg_delay_step;
  logic [WW-1:0] cfg_width_start;
  logic [WW-1:0] cfg_width_end;
  logic [WW-1:0] cfg_width_step;
  logic [RW-1:0] cfg_repeat;
  logic [TW-1:0] cfg_timeout;

  logic [RW-1:0] rep;
  logic [TW-1:0] tmo_cnt;

  logic [RW:0]   rep_inc;
  logic [RW:0]   rep_max;
  logic          rep_more;
  logic [WW:0]   w_next;
  logic          w_last;
  logic [DW:0]   d_next;
  logic          d_last;
  logic [TW-1:0] tmo_inc;
  logic          tmo_hit;

  // Two-flop synchroniser for the core-domain ready
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= ready_i;
      rdy_s    <= rdy_meta;
    end
  end

  // Grid advance, repeat and timeout arithmetic; one extra bit so overflow reads as exhausted
  always_comb begin
    rep_inc  = {1'b0, rep} + (RW+1)'(1);
    rep_max  = (cfg_repeat == '0) ? (RW+1)'(1) : {1'b0, cfg_repeat};
    rep_more = (rep_inc < rep_max);
    w_next   = {1'b0, cur_width_o} + {1'b0, cfg_width_step};
    w_last   = (cfg_width_step == '0) || (w_next > {1'b0, cfg_width_end}) ||
               (cfg_width_end < cfg_width_start);
    d_next   = {1'b0, cur_delay_o} + {1'b0, cfg_delay_step};
    d_last   = (cfg_delay_step == '0) || (d_next > {1'b0, cfg_delay_end}) ||
               (cfg_delay_end < cfg_delay_start);
    tmo_inc  = tmo_cnt + TW'(1);
    tmo_hit  = (cfg_timeout != '0) && (tmo_inc == cfg_timeout);
  end

  // Sweep sequencer with registered strobes; abort overrides everything but reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      cfg_delay_start <= '0;
      cfg_delay_end   <= '0;
      cfg_delay_step  <= '0;
      cfg_width_start <= '0;
      cfg_width_end   <= '0;
      cfg_width_step  <= '0;
      cfg_repeat      <= '0;
      cfg_timeout     <= '0;
      rep             <= '0;
      tmo_cnt         <= '0;
      fifo_dat_o      <= '0;
      fifo_we_o       <= 1'b0;
      en_o            <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
      cur_delay_o     <= '0;
      cur_width_o     <= '0;
      shot_cnt_o      <= '0;
    end else begin
      fifo_we_o <= 1'b0;
      en_o      <= 1'b0;
      done_o    <= 1'b0;
      if (abort_i) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              cfg_delay_start <= delay_start_i;
              cfg_delay_end   <= delay_end_i;
              cfg_delay_step  <= delay_step_i;
              cfg_width_start <= width_start_i;
              cfg_width_end   <= width_end_i;
              cfg_width_step  <= width_step_i;
              cfg_repeat      <= repeat_i;
              cfg_timeout     <= timeout_i;
              cur_delay_o     <= delay_start_i;
              cur_width_o     <= width_start_i;
              rep             <= '0;
              shot_cnt_o      <= '0;
              timeout_o       <= 1'b0;
              busy_o          <= 1'b1;
              state           <= S_PUSH;
            end
          end
          S_PUSH: begin
            if (!fifo_full_i) begin
              fifo_we_o  <= 1'b1;
              fifo_dat_o <= {cur_width_o, cur_delay_o};
              state      <= S_ARM;
            end
          end
          S_ARM: begin
            en_o       <= 1'b1;
            shot_cnt_o <= shot_cnt_o + 32'd1;
            tmo_cnt    <= '0;
            state      <= S_WAIT_LOW;
          end
          S_WAIT_LOW: begin
            if (!rdy_s) begin
              tmo_cnt <= '0;
              state   <= S_WAIT_HIGH;
            end else if (tmo_hit) begin
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          S_WAIT_HIGH: begin
            if (rdy_s) begin
              state <= S_NEXT;
            end else if (tmo_hit) begin
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          S_NEXT: begin
            if (rep_more) begin
              rep   <= RW'(rep_inc);
              state <= S_PUSH;
            end else begin
              rep <= '0;
              if (!w_last) begin
                cur_width_o <= WW'(w_next);
                state       <= S_PUSH;
              end else if (!d_last) begin
                cur_delay_o <= DW'(d_next);
                cur_width_o <= cfg_width_start;
                state       <= S_PUSH;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Scoreboard bench for glitch_sweep_ctrl: a nested-loop grid model queues expected FIFO words,
// a monitor pops them on each write strobe; a simple core model answers en_o with ready.
module tb_glitch_sweep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [15:0] delay_start_i, delay_end_i, delay_step_i;
  logic [15:0] width_start_i, width_end_i, width_step_i;
  logic [7:0]  repeat_i;
  logic [15:0] timeout_i;
  logic [31:0] fifo_dat_o;
  logic        fifo_we_o;
  logic        fifo_full_i;
  logic        en_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [15:0] cur_delay_o;
  logic [15:0] cur_width_o;
  logic [31:0] shot_cnt_o;

  glitch_sweep_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .delay_start_i(delay_start_i), .delay_end_i(delay_end_i), .delay_step_i(delay_step_i),
    .width_start_i(width_start_i), .width_end_i(width_end_i), .width_step_i(width_step_i),
    .repeat_i(repeat_i), .timeout_i(timeout_i),
    .fifo_dat_o(fifo_dat_o), .fifo_we_o(fifo_we_o), .fifo_full_i(fifo_full_i),
    .en_o(en_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .cur_delay_o(cur_delay_o), .cur_width_o(cur_width_o),
    .shot_cnt_o(shot_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          en_cnt = 0;
  int          done_cnt = 0;
  logic        prev_we = 1'b0;
  logic        core_stuck = 1'b0;
  int          core_low_fix = 0;
  int          exp_n, exp_ld, exp_lw;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference grid: outer delay loop, inner width loop, repeat per point
  task automatic model_push(input int ds, input int de, input int dst, input int ws,
                            input int we, input int wst, input int rp,
                            output int n, output int ld, output int lw);
    int d, w, r;
    logic [31:0] word;
    r = (rp == 0) ? 1 : rp;
    n = 0;
    d = ds;
    forever begin
      w = ws;
      forever begin
        word = {w[15:0], d[15:0]};
        for (int k = 0; k < r; k++) exp_q.push_back(word);
        n += r;
        lw = w;
        if (wst == 0 || w + wst > we || we < ws) break;
        w += wst;
      end
      ld = d;
      if (dst == 0 || d + dst > de || de < ds) break;
      d += dst;
    end
  endtask

  // Monitor: scoreboard pop on each FIFO write plus strobe relationships
  always begin
    @(posedge clk_i);
    #1;
    if (!rst_i) begin
      if (fifo_we_o) begin
        check("write_while_full", {63'd0, fifo_full_i}, 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %0h expected no write", fifo_dat_o);
        end else begin
          check("fifo_word", {32'd0, fifo_dat_o}, {32'd0, exp_q.pop_front()});
        end
      end
      if (prev_we || en_o) check("en_follows_we", {63'd0, en_o}, {63'd0, prev_we});
      if (en_o) en_cnt++;
      if (done_o) begin
        done_cnt++;
        check("busy_low_with_done", {63'd0, busy_o}, 64'd0);
      end
      prev_we = fifo_we_o;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Core model: ready drops a little after each arm pulse, then returns
  initial begin
    int pre, low;
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (en_o && !core_stuck) begin
        pre = $urandom_range(3, 1);
        low = (core_low_fix != 0) ? core_low_fix : $urandom_range(4, 1);
        repeat (pre) @(negedge clk_i);
        ready_i = 1'b0;
        repeat (low) @(negedge clk_i);
        ready_i = 1'b1;
      end
    end
  end

  task automatic begin_sweep(input int ds, input int de, input int dst, input int ws,
                             input int we, input int wst, input int rp, input int tmo);
    model_push(ds, de, dst, ws, we, wst, rp, exp_n, exp_ld, exp_lw);
    @(negedge clk_i);
    delay_start_i = 16'(ds);
    delay_end_i   = 16'(de);
    delay_step_i  = 16'(dst);
    width_start_i = 16'(ws);
    width_end_i   = 16'(we);
    width_step_i  = 16'(wst);
    repeat_i      = 8'(rp);
    timeout_i     = 16'(tmo);
    start_i       = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    check("timeout_cleared_on_start", {63'd0, timeout_o}, 64'd0);
  endtask

  task automatic wait_idle(input int lim, input bit rand_full);
    int i;
    i = 0;
    while (busy_o === 1'b1 && i < lim) begin
      @(negedge clk_i);
      if (rand_full) fifo_full_i = ($urandom_range(3, 0) == 0);
      i++;
    end
    fifo_full_i = 1'b0;
    if (i >= lim) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", lim);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic finish_sweep(input int base_en, input int base_done, input bit rand_full);
    wait_idle(20000, rand_full);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("shot_cnt", {32'd0, shot_cnt_o}, 64'(exp_n));
    check("en_pulses", 64'(en_cnt - base_en), 64'(exp_n));
    check("done_pulses", 64'(done_cnt - base_done), 64'd1);
    check("cur_delay_final", {48'd0, cur_delay_o}, 64'(exp_ld));
    check("cur_width_final", {48'd0, cur_width_o}, 64'(exp_lw));
    check("no_timeout", {63'd0, timeout_o}, 64'd0);
  endtask

  task automatic do_sweep(input int ds, input int de, input int dst, input int ws,
                          input int we, input int wst, input int rp, input bit rand_full);
    int be, bd;
    be = en_cnt;
    bd = done_cnt;
    begin_sweep(ds, de, dst, ws, we, wst, rp, 0);
    finish_sweep(be, bd, rand_full);
  endtask

  initial begin
    int be, bd, i, c;
    int ds, de, dst, ws, we, wst, rp, base;
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    fifo_full_i = 1'b0;
    delay_start_i = '0; delay_end_i = '0; delay_step_i = '0;
    width_start_i = '0; width_end_i = '0; width_step_i = '0;
    repeat_i = '0;
    timeout_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_we", {63'd0, fifo_we_o}, 64'd0);
    check("rst_en", {63'd0, en_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_timeout", {63'd0, timeout_o}, 64'd0);
    check("rst_dat", {32'd0, fifo_dat_o}, 64'd0);
    check("rst_cur", {32'd0, cur_width_o, cur_delay_o}, 64'd0);
    check("rst_shot_cnt", {32'd0, shot_cnt_o}, 64'd0);
    repeat (3) @(negedge clk_i);

    // T1: 3x2 grid, in order
    do_sweep(10, 30, 10, 1, 2, 1, 1, 1'b0);

    // T2: FIFO full held for 20 cycles before the first write
    be = en_cnt;
    bd = done_cnt;
    fifo_full_i = 1'b1;
    begin_sweep(7, 7, 0, 3, 3, 0, 1, 0);
    repeat (20) @(negedge clk_i);
    check("full_no_en", 64'(en_cnt - be), 64'd0);
    check("full_no_pop", 64'(exp_q.size()), 64'd1);
    fifo_full_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("we_when_full_drops", {63'd0, fifo_we_o}, 64'd1);
    @(posedge clk_i);
    #1;
    check("en_after_write", {63'd0, en_o}, 64'd1);
    finish_sweep(be, bd, 1'b0);

    // T3: ready stuck high -> timeout after 50 cycles in WAIT_LOW
    core_stuck = 1'b1;
    be = en_cnt;
    bd = done_cnt;
    begin_sweep(5, 5, 1, 9, 9, 1, 1, 50);
    i = 0;
    while (!en_o && i < 100) begin
      @(posedge clk_i);
      #1;
      i++;
    end
    c = 0;
    while (!timeout_o && c < 200) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    check("timeout_latency", 64'(c), 64'd50);
    check("timeout_busy", {63'd0, busy_o}, 64'd0);
    wait_idle(100, 1'b0);
    check("timeout_sticky", {63'd0, timeout_o}, 64'd1);
    check("timeout_no_done", 64'(done_cnt - bd), 64'd0);
    check("timeout_shot_cnt", {32'd0, shot_cnt_o}, 64'd1);
    check("timeout_queue", 64'(exp_q.size()), 64'd0);
    core_stuck = 1'b0;
    do_sweep(1, 2, 1, 4, 4, 0, 1, 1'b0);

    // T4: zero delay step, inverted width range, repeat 0 -> one shot
    do_sweep(100, 500, 0, 20, 10, 3, 0, 1'b0);

    // T5: delay advance overflowing 16 bits ends the sweep
    do_sweep(32'h8000, 32'hFFFF, 32'h8000, 2, 2, 0, 1, 1'b0);

    // Repeats per point
    do_sweep(3, 4, 1, 8, 9, 1, 3, 1'b0);

    // T6: abort in WAIT_HIGH of shot 3, then abort+start together in IDLE
    core_low_fix = 20;
    be = en_cnt;
    bd = done_cnt;
    begin_sweep(0, 4, 1, 5, 5, 1, 1, 0);
    i = 0;
    while (en_cnt - be < 3 && i < 2000) begin
      @(negedge clk_i);
      i++;
    end
    i = 0;
    while (ready_i && i < 100) begin
      @(negedge clk_i);
      i++;
    end
    repeat (5) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_shot_cnt", {32'd0, shot_cnt_o}, 64'd3);
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check("abort_start_ignored", {63'd0, busy_o}, 64'd0);
    check("abort_start_shot_cnt", {32'd0, shot_cnt_o}, 64'd3);
    check("abort_no_done", 64'(done_cnt - bd), 64'd0);
    check("abort_left_in_queue", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    core_low_fix = 0;
    repeat (30) @(negedge clk_i);

    // Randomized grids with random FIFO back-pressure, some near the top of the range
    for (int t = 0; t < 8; t++) begin
      base = ($urandom_range(2, 0) == 0) ? 32'hFFF8 : 0;
      ds  = base + $urandom_range(7, 0);
      de  = ds + $urandom_range(6, 0) - 1;
      if (de > 32'hFFFF) de = 32'hFFFF;
      if (de < 0) de = 0;
      dst = $urandom_range(4, 0);
      ws  = base + $urandom_range(7, 0);
      we  = ws + $urandom_range(6, 0) - 1;
      if (we > 32'hFFFF) we = 32'hFFFF;
      if (we < 0) we = 0;
      wst = $urandom_range(4, 0);
      rp  = $urandom_range(3, 0);
      do_sweep(ds, de, dst, ws, we, wst, rp, 1'b1);
    end

    // Reset mid-sweep returns everything to reset values
    begin_sweep(0, 9, 1, 0, 9, 1, 1, 0);
    be = en_cnt;
    i = 0;
    while (en_cnt == be && i < 200) begin
      @(negedge clk_i);
      i++;
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_shot_cnt", {32'd0, shot_cnt_o}, 64'd0);
    check("midrst_cur", {32'd0, cur_width_o, cur_delay_o}, 64'd0);
    exp_q.delete();
    repeat (20) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
